// File: rtl/apb_ram_master.sv
// Single-outstanding APB initiator bridging a RAM-style requester to an APB responder.
// The requester is stalled until PREADY or until TIMEOUT_CYCLES wait cycles abort the transfer.
module apb_ram_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);

    // A zero timeout still needs a legal one-bit counter even though it never expires.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      paddr_q, paddr_d;
    logic [31:0]      pwdata_q, pwdata_d;
    logic             pwrite_q, pwrite_d;
    logic             psel_q, psel_d;
    logic             penable_q, penable_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             req;

    assign req = ren | wen;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d  = SETUP;
                    paddr_d  = addr;
                    pwdata_d = wdata;
                    pwrite_d = wen;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d = DONE;
                    if (!pwrite_q) rdata_d = PRDATA;
                end else begin
                    cnt_d = cnt_inc;
                    if (TIMEOUT_CYCLES != 0 && cnt_inc == CNT_LIMIT) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        if (!pwrite_q) rdata_d = ERR_RDATA;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bus strobes are decoded from the next state so they leave a flop glitch-free.
        psel_d    = (state_d == SETUP) || (state_d == ACCESS);
        penable_d = (state_d == ACCESS);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // In IDLE the stall must rise in the very cycle a request appears.
    assign busy    = (state_q == SETUP) || (state_q == ACCESS) || ((state_q == IDLE) && req);
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;

endmodule

// File: tb/tb_apb_ram_master.sv
// Bench for apb_ram_master: RAM responder with planned wait states, a timeline model of the
// expected bus/requester behaviour checked every cycle, plus directed literal expectations.
module tb_apb_ram_master;

    localparam int          T    = 4;
    localparam logic [31:0] ERRV = 32'hBAD1BAD1;

    logic        CLK   = 1'b0;
    logic        nRST  = 1'b1;
    logic        ren   = 1'b0;
    logic        wen   = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;

    always #5 CLK = ~CLK;

    apb_ram_master #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERRV)) dut (
        .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
        .busy(busy), .rdata(rdata), .err(err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
    endfunction

    // Responder: RAM contents, PREADY raised after plan_wait ACCESS cycles.
    logic [31:0] resp_mem [logic [31:0]];
    int          plan_wait = 0;
    int          acc_cnt   = 0;

    always @(posedge CLK) begin
        if (nRST && PSEL && PENABLE && PREADY && PWRITE) resp_mem[PADDR] = PWDATA;
        #1;
        if (PSEL && PENABLE) begin
            if (acc_cnt == plan_wait) begin
                PREADY = 1'b1;
                PRDATA = resp_mem.exists(PADDR) ? resp_mem[PADDR] : mem_init(PADDR);
            end else begin
                PREADY = 1'b0;
                PRDATA = $urandom;
            end
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            PREADY  = 1'($urandom_range(0, 1));
            PRDATA  = $urandom;
        end
    end

    // Model: offset d from the acceptance cycle; transfer ends at offset dlen.
    logic [31:0] m_mem [logic [31:0]];
    int          d, dlen;
    bit          m_abort, m_write;
    logic [31:0] m_paddr, m_pwdata, m_rdata;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        return m_mem.exists(a) ? m_mem[a] : mem_init(a);
    endfunction

    always @(negedge CLK or negedge nRST) begin : model
        bit e_busy, e_psel, e_pen, e_err;
        if (!nRST) begin
            d = 0; dlen = 0; m_abort = 0; m_write = 0;
            m_paddr = '0; m_pwdata = '0; m_rdata = '0;
        end else begin
            if (d == 0) begin
                e_busy = ren | wen; e_psel = 0; e_pen = 0; e_err = 0;
            end else if (d == 1) begin
                e_busy = 1; e_psel = 1; e_pen = 0; e_err = 0;
            end else if (d < dlen) begin
                e_busy = 1; e_psel = 1; e_pen = 1; e_err = 0;
            end else begin
                if (m_write && !m_abort) m_mem[m_paddr] = m_pwdata;
                if (!m_write) m_rdata = m_abort ? ERRV : m_read(m_paddr);
                e_busy = 0; e_psel = 0; e_pen = 0; e_err = m_abort;
            end
            check("busy", busy, e_busy);
            check("psel", PSEL, e_psel);
            check("penable", PENABLE, e_pen);
            check("err", err, e_err);
            check("paddr", PADDR, m_paddr);
            check("pwdata", PWDATA, m_pwdata);
            check("pwrite", PWRITE, m_write);
            check("rdata", rdata, m_rdata);
            if (d == 0) begin
                if (ren | wen) begin
                    m_paddr = addr; m_pwdata = wdata; m_write = wen;
                    if (plan_wait < T) begin dlen = 3 + plan_wait; m_abort = 0; end
                    else begin dlen = 2 + T; m_abort = 1; end
                    d = 1;
                end
            end else if (d == dlen) begin
                d = 0;
            end else begin
                d++;
            end
        end
    end

    // Holds the request until busy falls; returns one cycle later with the request still driven.
    task automatic do_xfer(input bit r, input bit w, input logic [31:0] a, input logic [31:0] wd,
                           input int wt, output int lat, output logic e, output logic [31:0] rd);
        bit done = 0;
        plan_wait = wt; ren = r; wen = w; addr = a; wdata = wd;
        lat = 0; e = 0; rd = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            if (!busy) begin
                e = err; rd = rdata; done = 1;
                break;
            end
            lat++;
        end
        check("xfer_completes", done, 1);
        @(posedge CLK); #1;
    endtask

    task automatic idle_cycles(input int n);
        ren = 0; wen = 0;
        repeat (n) @(posedge CLK);
        if (n > 0) #1;
    endtask

    initial begin
        int          lat;
        logic        e;
        logic [31:0] rd;

        #1 nRST = 0;
        #2;
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy", busy, 0);
        #14 nRST = 1;
        @(posedge CLK); #1;

        do_xfer(0, 1, 32'h40, 32'hDEADBEEF, 0, lat, e, rd);
        check("wr0_latency", lat, 3);
        check("wr0_err", e, 0);
        check("wr0_paddr_held", PADDR, 32'h40);
        check("wr0_pwdata_held", PWDATA, 32'hDEADBEEF);
        check("wr0_pwrite_held", PWRITE, 1);
        idle_cycles(1);

        resp_mem[32'h80] = 32'h12345678;
        m_mem[32'h80]    = 32'h12345678;
        do_xfer(1, 0, 32'h80, 32'h0, 3, lat, e, rd);
        check("rd_wait_latency", lat, 6);
        check("rd_wait_rdata", rd, 32'h12345678);
        check("rd_wait_err", e, 0);
        idle_cycles(0);

        do_xfer(1, 0, 32'h84, 32'h0, 20, lat, e, rd);
        check("timeout_latency", lat, 6);
        check("timeout_err", e, 1);
        check("timeout_rdata", rd, ERRV);
        idle_cycles(0);
        @(negedge CLK);
        check("timeout_err_pulse", err, 0);
        @(posedge CLK); #1;

        do_xfer(0, 1, 32'h88, 32'h55, 4, lat, e, rd);
        check("wr_abort_latency", lat, 6);
        check("wr_abort_err", e, 1);
        check("wr_abort_rdata_kept", rd, ERRV);
        idle_cycles(2);

        do_xfer(1, 1, 32'h90, 32'hCAFEF00D, 0, lat, e, rd);
        check("both_pwrite", PWRITE, 1);
        do_xfer(1, 0, 32'h90, 32'h0, 0, lat, e, rd);
        check("both_readback", rd, 32'hCAFEF00D);
        do_xfer(0, 1, 32'h200, 32'hA5A50001, 0, lat, e, rd);
        do_xfer(1, 0, 32'h200, 32'h0, 1, lat, e, rd);
        check("b2b_latency", lat, 4);
        check("b2b_rdata", rd, 32'hA5A50001);
        idle_cycles(1);

        plan_wait = 10; ren = 1; addr = 32'h100;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("mid_psel", PSEL, 1);
        check("mid_penable", PENABLE, 1);
        #1 nRST = 0; ren = 0;
        #1;
        check("async_psel", PSEL, 0);
        check("async_penable", PENABLE, 0);
        check("async_paddr", PADDR, 0);
        #1 nRST = 1;
        @(negedge CLK);
        check("post_rst_busy", busy, 0);
        @(posedge CLK); #1;

        for (int i = 0; i < 300; i++) begin
            int k;
            k = $urandom_range(0, 2);
            do_xfer(k != 1, k != 0, 32'h1000 + 4 * $urandom_range(0, 15), $urandom,
                    $urandom_range(0, 5), lat, e, rd);
            if ($urandom_range(0, 2) != 0) idle_cycles($urandom_range(0, 2));
        end
        idle_cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
